fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage of the RISC pipeline: owns the program counter, drives the word address into the combinational instruction memory, and registers the returned instruction into the IF/ID pipeline register for decode. It handles stalls, branch/jump redirects with bubble insertion, and a halt on ECALL. It sits directly upstream of the instruction memory and directly upstream of decode.

## Interface
- IMW, 4, instruction-memory address width in words (2**IMW words)
- IW, 32, instruction width
- NOP, 32'h00000013, bubble encoding (ADDI x0,x0,0)
- HALT_INSN, 32'h00000073, instruction that halts fetch (ECALL)
- CW, 16, fetch-counter width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- im_addr  out  IMW  word address to instruction memory (= pc[IMW+1:2]), combinational from pc
- im_data  in  IW  instruction returned by memory, same cycle
- stall  in  1  hold PC and IF/ID (hazard from decode)
- redirect  in  1  taken branch/jump this cycle
- redirect_pc  in  IMW+2  byte target of redirect
- pc  out  IMW+2  current fetch byte address
- if_id_instr  out  IW  registered instruction to decode
- if_id_pc  out  IMW+2  byte address of if_id_instr
- if_id_valid  out  1  if_id_instr is a real fetched instruction
- halted  out  1  fetch has halted
- fetch_count  out  CW  number of valid instructions latched into IF/ID, saturating

## Operation
- State machine: BOOT, RUN, HALTED (2-bit state).
- Reset (async): state=BOOT, pc=0, if_id_instr=NOP, if_id_pc=0, if_id_valid=0, halted=0, fetch_count=0.
- BOOT: one cycle; pc held at 0, IF/ID loads bubble; next state RUN. stall/redirect ignored in BOOT.
- RUN, per edge, priority redirect > stall > normal:
  - redirect: pc <= {redirect_pc[IMW+1:2],2'b00} (low two bits forced to 0); IF/ID loads bubble (instr=NOP, valid=0, pc=0). Redirect overrides a simultaneous stall.
  - stall (no redirect): pc, IF/ID, fetch_count all hold.
  - normal: if_id_instr<=im_data, if_id_pc<=pc, if_id_valid<=1, fetch_count+=1 (saturates at 2**CW-1); pc<=pc+4, wrapping from (2**IMW-1)*4 to 0 (natural IMW+2-bit overflow).
  - If a normal fetch latches im_data==HALT_INSN: it is still latched (valid=1, counted); next state HALTED, pc not advanced.
- HALTED: halted=1; pc holds; every edge IF/ID loads bubble; stall/redirect ignored; exit only by reset.
- im_addr always equals pc[IMW+1:2], including in BOOT and HALTED.
- Bubble = {instr=NOP, pc=0, valid=0}.

## Timing
- Fetch latency: instruction at pc appears on if_id_instr 1 cycle later (memory combinational).
- Redirect penalty: one bubble; target instruction on IF/ID 2 edges after redirect sampled.
- Throughput: one instruction per cycle when stall=0, redirect=0.
- halted asserts on the edge following the edge that latched HALT_INSN (registered from state).
- rst assertion mid-operation clears all outputs immediately (asynchronously); first RUN fetch from pc=0 occurs on second edge after rst deasserts.

## Test plan
- Reset then run with memory word k = 32'h1000_0000+k: if_id_instr sequence NOP (BOOT), 0x10000000, 0x10000001...; if_id_pc 0,4,8; fetch_count increments 1,2,3.
- Free-run 16 fetches with IMW=4: pc goes 60 -> 0; if_id_pc wraps 0x3C then 0x00; no glitch in valid.
- stall high for 3 cycles at pc=8: pc, if_id_instr, if_id_pc, fetch_count unchanged for 3 edges; resume with word 2.
- redirect to 0x1F with stall also high: pc becomes 0x1C, next IF/ID is bubble (valid=0, NOP), following IF/ID holds word 7 with if_id_pc=0x1C.
- Word 5 = 0x00000073: IF/ID holds it valid, halted=1 next cycle, pc stays 0x14, subsequent IF/ID bubbles, redirect ignored.
- Assert rst asynchronously mid-run between edges: all outputs return to reset values before next edge; BOOT bubble then word 0 after release.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the combinational instruction
// memory and registers the returned word into IF/ID, with stall, redirect and ECALL halt.
module fetch_stage #(
  parameter int              IMW       = 4,
  parameter int              IW        = 32,
  parameter logic [IW-1:0]   NOP       = 'h00000013,
  parameter logic [IW-1:0]   HALT_INSN = 'h00000073,
  parameter int              CW        = 16
) (
  input  logic             clk,
  input  logic             rst,
  output logic [IMW-1:0]   im_addr,
  input  logic [IW-1:0]    im_data,
  input  logic             stall,
  input  logic             redirect,
  input  logic [IMW+1:0]   redirect_pc,
  output logic [IMW+1:0]   pc,
  output logic [IW-1:0]    if_id_instr,
  output logic [IMW+1:0]   if_id_pc,
  output logic             if_id_valid,
  output logic             halted,
  output logic [CW-1:0]    fetch_count
);

  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HALTED = 2'd2} state_e;

  state_e           state_q, state_d;
  logic [IMW+1:0]   pc_q, pc_d;
  logic [IW-1:0]    instr_q, instr_d;
  logic [IMW+1:0]   ifpc_q, ifpc_d;
  logic             valid_q, valid_d;
  logic [CW-1:0]    count_q, count_d;
  logic             halted_q;

  // Redirect targets are word aligned; masking keeps every input bit in use.
  logic [IMW+1:0]   redir_aligned;
  assign redir_aligned = redirect_pc & ~(IMW+2)'(3);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = NOP;
    ifpc_d  = '0;
    valid_d = 1'b0;
    count_d = count_q;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (redirect) begin
          pc_d = redir_aligned;
        end else if (stall) begin
          instr_d = instr_q;
          ifpc_d  = ifpc_q;
          valid_d = valid_q;
        end else begin
          instr_d = im_data;
          ifpc_d  = pc_q;
          valid_d = 1'b1;
          count_d = (count_q == '1) ? count_q : count_q + 1'b1;
          if (im_data == HALT_INSN) state_d = HALTED;
          else                      pc_d    = pc_q + (IMW+2)'(4);
        end
      end
      HALTED: state_d = HALTED;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= BOOT;
      pc_q     <= '0;
      instr_q  <= NOP;
      ifpc_q   <= '0;
      valid_q  <= 1'b0;
      count_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      ifpc_q   <= ifpc_d;
      valid_q  <= valid_d;
      count_q  <= count_d;
      // Lags the state by one edge so decode sees the ECALL before halted rises.
      halted_q <= (state_q == HALTED);
    end
  end

  assign im_addr     = pc_q[IMW+1:2];
  assign pc          = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc    = ifpc_q;
  assign if_id_valid = valid_q;
  assign halted      = halted_q;
  assign fetch_count = count_q;

endmodule
